// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Counter width able to hold the values 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported backing memory between fetch and data requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state;
  arb_state_t next_state;
  owner_t     owner;
  logic       grant_i;
  logic       grant_d;
  logic       at_limit;
  logic       starve_inc;
  logic       starve_clr;

  // Data has priority unless fetch has already been passed over the limit.
  assign starve_inc = grant_d & i_req;
  assign starve_clr = grant_i | (grant_d & ~i_req);

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision; requests are only sampled in IDLE.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || !at_limit)) begin
          grant_d    = 1'b1;
          next_state = BUSY;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch the granted request and capture the response for its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_I;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant_d) begin
        owner     <= OWN_D;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        owner     <= OWN_I;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
      if ((state == BUSY) && mem_ack) begin
        if (owner == OWN_D) begin
          d_ack <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req = (state == BUSY);
  assign busy    = (state != IDLE);
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_i_ack;
    logic        e_d_ack;
    logic [31:0] e_i_rdata;
    logic [31:0] e_d_rdata;
    logic        e_i_stall;
    logic        e_d_stall;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_req     = v.i_req;
    i_addr    = v.i_addr;
    d_req     = v.d_req;
    d_we      = v.d_we;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    mem_ack   = v.mem_ack;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    chk($sformatf("row%0d mem_req", idx), 32'(mem_req), 32'(v.e_mem_req));
    if (v.e_mem_req) begin
      chk($sformatf("row%0d mem_we", idx), 32'(mem_we), 32'(v.e_mem_we));
      chk($sformatf("row%0d mem_addr", idx), mem_addr, v.e_mem_addr);
      if (v.e_mem_we) begin
        chk($sformatf("row%0d mem_wdata", idx), mem_wdata, v.e_mem_wdata);
      end
    end
    chk($sformatf("row%0d i_ack", idx), 32'(i_ack), 32'(v.e_i_ack));
    chk($sformatf("row%0d d_ack", idx), 32'(d_ack), 32'(v.e_d_ack));
    chk($sformatf("row%0d i_rdata", idx), i_rdata, v.e_i_rdata);
    chk($sformatf("row%0d d_rdata", idx), d_rdata, v.e_d_rdata);
    chk($sformatf("row%0d i_stall", idx), 32'(i_stall), 32'(v.e_i_stall));
    chk($sformatf("row%0d d_stall", idx), 32'(d_stall), 32'(v.e_d_stall));
    chk($sformatf("row%0d busy", idx), 32'(busy), 32'(v.e_busy));
  endtask

  task automatic setInputs(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                           input logic [31:0] da, input logic ma, input logic [31:0] md);
    i_req     = ir;
    i_addr    = ia;
    d_req     = dr;
    d_we      = dw;
    d_addr    = da;
    d_wdata   = 32'h0;
    mem_ack   = ma;
    mem_rdata = md;
  endtask

  initial begin
    reset = 1'b1;
    setInputs(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset i_ack", 32'(i_ack), 0);
    chk("reset d_ack", 32'(d_ack), 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset busy", 32'(busy), 0);
    @(negedge clk);

    // Lone fetch, memory answers three cycles after the grant.
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, 0, 0,          1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, 0, 0,          1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 1, 32'h11111111,    0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0});
    // Collision: store wins, fetch follows right after the store response.
    vecs.push_back(vec_t'{1, 32'h80, 1, 1, 32'h100, 32'h5, 0, 0,          0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 1, 0});
    vecs.push_back(vec_t'{1, 32'h80, 1, 1, 32'h100, 32'h5, 1, 32'h12345678, 1, 1, 32'h100, 32'h5, 0, 0, 32'hDEADBEEF, 0, 1, 1, 1});
    vecs.push_back(vec_t'{1, 32'h80, 1, 1, 32'h100, 32'h5, 0, 0,          0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 32'h80, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 32'h80, 0, 0, 0, 0, 1, 32'hCAFEF00D,         1, 0, 32'h80, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 32'h80, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0});
    // Load with k = 2: d_stall stays high until the d_ack cycle.
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h700, 0, 0, 0,       0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h700, 0, 0, 0,       1, 0, 32'h700, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h700, 0, 0, 0,       1, 0, 32'h700, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h700, 0, 1, 32'h777, 1, 0, 32'h700, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h700, 0, 0, 0,       0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 32'h777, 0, 0, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h777, 0, 0, 0});

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r]);
      #1;
      checkOutput(vecs[r], r);
      @(negedge clk);
    end

    // Starvation: both requests held with k = 0; four loads then the fetch, then data again.
    for (int a = 0; a < 6; a++) begin
      logic exp_d;
      exp_d = (a != 4);
      setInputs(1, 32'h200, 1, 0, 32'h300, 1, 0);
      #1;
      chk($sformatf("starve%0d idle busy", a), 32'(busy), 0);
      @(negedge clk);
      setInputs(1, 32'h200, 1, 0, 32'h300, 1, 32'h1000 + a);
      #1;
      chk($sformatf("starve%0d mem_req", a), 32'(mem_req), 1);
      chk($sformatf("starve%0d mem_addr", a), mem_addr, exp_d ? 32'h300 : 32'h200);
      @(negedge clk);
      setInputs(1, 32'h200, 1, 0, 32'h300, 1, 0);
      #1;
      chk($sformatf("starve%0d d_ack", a), 32'(d_ack), 32'(exp_d));
      chk($sformatf("starve%0d i_ack", a), 32'(i_ack), 32'(!exp_d));
      if (exp_d) chk($sformatf("starve%0d d_rdata", a), d_rdata, 32'h1000 + a);
      else       chk($sformatf("starve%0d i_rdata", a), i_rdata, 32'h1000 + a);
      @(negedge clk);
    end
    setInputs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Zero-latency memory: back-to-back loads acknowledge every third cycle.
    for (int c = 0; c < 9; c++) begin
      setInputs(0, 0, 1, 0, 32'h400, 1, 32'hA0000000 + c);
      #1;
      chk($sformatf("zl%0d d_ack", c), 32'(d_ack), 32'((c % 3) == 2));
      chk($sformatf("zl%0d mem_req", c), 32'(mem_req), 32'((c % 3) == 1));
      if ((c % 3) == 2) chk($sformatf("zl%0d d_rdata", c), d_rdata, 32'hA0000000 + c - 1);
      @(negedge clk);
    end
    setInputs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset during the second BUSY cycle of a fetch, then a late mem_ack.
    setInputs(1, 32'h500, 0, 0, 0, 0, 0);
    #1;
    chk("rst idle mem_req", 32'(mem_req), 0);
    @(negedge clk);
    #1;
    chk("rst busy1 mem_addr", mem_addr, 32'h500);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst busy2 mem_req", 32'(mem_req), 1);
    @(negedge clk);
    reset = 1'b0;
    setInputs(0, 0, 0, 0, 0, 1, 32'hBADBAD);
    #1;
    chk("rst after mem_req", 32'(mem_req), 0);
    chk("rst after i_ack", 32'(i_ack), 0);
    chk("rst after busy", 32'(busy), 0);
    chk("rst after i_rdata", i_rdata, 0);
    chk("rst after d_rdata", d_rdata, 0);
    @(negedge clk);
    setInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst late i_ack", 32'(i_ack), 0);
    chk("rst late i_rdata", i_rdata, 0);
    chk("rst late busy", 32'(busy), 0);
    @(negedge clk);
    setInputs(1, 32'h600, 0, 0, 0, 0, 0);
    #1;
    chk("post idle mem_req", 32'(mem_req), 0);
    @(negedge clk);
    setInputs(1, 32'h600, 0, 0, 0, 1, 32'h600D);
    #1;
    chk("post busy mem_req", 32'(mem_req), 1);
    chk("post busy mem_addr", mem_addr, 32'h600);
    @(negedge clk);
    setInputs(1, 32'h600, 0, 0, 0, 0, 0);
    #1;
    chk("post resp i_ack", 32'(i_ack), 1);
    chk("post resp i_rdata", i_rdata, 32'h600D);
    @(negedge clk);
    setInputs(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post done i_ack", 32'(i_ack), 0);
    chk("post done busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
